// File: rtl/transfer_sequencer.sv
// Transfer instruction issue stage: fetches 26-bit transfer instructions and holds each on
// the instruction bus for its step count, generating per-step source/destination addresses.
module transfer_sequencer #(
  parameter int IMEM_DEPTH = 8192,
  parameter int PC_W       = 13,
  parameter int COUNT_W    = 6
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            hold,
  output logic [PC_W-1:0] imem_addr,
  input  logic [25:0]     imem_data,
  output logic [25:0]     instruction,
  output logic            instr_valid,
  output logic [7:0]      next_source,
  output logic [7:0]      next_destination,
  output logic            done
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ISSUE,
    DONE
  } state_t;

  localparam logic [PC_W-1:0] LAST_PC = PC_W'(IMEM_DEPTH - 1);

  state_t              state, state_nxt;
  logic [PC_W-1:0]     pc, pc_nxt;
  logic [COUNT_W-1:0]  step, step_nxt;
  logic [25:0]         instr_q, instr_nxt;
  logic [COUNT_W-1:0]  count_field;
  logic [COUNT_W-1:0]  last_step_idx;
  logic                last_step;

  // Block transfers (type 0x) run count steps with count 0 treated as 1; single transfers run 1.
  assign count_field = instr_q[COUNT_W-1:0];
  always_comb begin
    last_step_idx = '0;
    if (!instr_q[25] && count_field != '0) last_step_idx = count_field - COUNT_W'(1);
  end
  assign last_step = (step == last_step_idx);

  // NOTE: every variable gets a default first so no path through the case infers a latch.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    step_nxt  = step;
    instr_nxt = instr_q;
    case (state)
      IDLE: begin
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        instr_nxt = imem_data;
        step_nxt  = '0;
        state_nxt = ISSUE;
      end
      ISSUE: begin
        if (!hold) begin
          if (!last_step) begin
            step_nxt = step + COUNT_W'(1);
          end else if (pc == LAST_PC) begin
            state_nxt = DONE;
          end else begin
            pc_nxt    = pc + PC_W'(1);
            state_nxt = start ? FETCH : IDLE;
          end
        end
      end
      DONE: begin
        state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      pc      <= '0;
      step    <= '0;
      instr_q <= '0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      step    <= step_nxt;
      instr_q <= instr_nxt;
    end
  end

  assign imem_addr   = pc;
  assign instruction = instr_q;
  assign instr_valid = (state == ISSUE);
  assign done        = (state == DONE);

  // Addresses are only meaningful while issuing; they read zero in every other state.
  assign next_source      = instr_valid ? instr_q[21:14] + 8'(step) : 8'd0;
  assign next_destination = instr_valid ? instr_q[13:6]  + 8'(step) : 8'd0;

endmodule

// File: tb/tb_transfer_sequencer.sv
// Bench for transfer_sequencer: directed vector table, a small-depth DONE instance,
// and randomized instruction streams checked against a beat-queue reference model.
module tb_transfer_sequencer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Main instance (default depth)
  logic        reset, start, hold;
  logic [12:0] imem_addr;
  logic [25:0] imem_data, instruction;
  logic        instr_valid, done;
  logic [7:0]  next_source, next_destination;
  logic [25:0] imem [0:8191];
  assign imem_data = imem[imem_addr];

  transfer_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .hold(hold),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .instruction(instruction), .instr_valid(instr_valid),
    .next_source(next_source), .next_destination(next_destination), .done(done)
  );

  // Four-word instance for end-of-memory behaviour
  logic        reset4, start4, hold4;
  logic [1:0]  imem_addr4;
  logic [25:0] imem_data4, instruction4;
  logic        instr_valid4, done4;
  logic [7:0]  next_source4, next_destination4;
  logic [25:0] imem4 [0:3];
  assign imem_data4 = imem4[imem_addr4];

  transfer_sequencer #(.IMEM_DEPTH(4), .PC_W(2), .COUNT_W(6)) dut4 (
    .clock(clock), .reset(reset4), .start(start4), .hold(hold4),
    .imem_addr(imem_addr4), .imem_data(imem_data4),
    .instruction(instruction4), .instr_valid(instr_valid4),
    .next_source(next_source4), .next_destination(next_destination4), .done(done4)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [25:0] mkw(input int typ, input int src, input int dst, input int cnt);
    return {2'(typ), 2'b00, 8'(src), 8'(dst), 6'(cnt)};
  endfunction

  // One row: inputs applied for the next edge, outputs expected after it
  typedef struct {
    logic rst, st, hd;
    int   addr;
    logic val;
    int   src, dst;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t v(input logic rst, input logic st, input logic hd,
                             input int addr, input logic val, input int src, input int dst);
    vec_t r;
    r.rst = rst; r.st = st; r.hd = hd;
    r.addr = addr; r.val = val; r.src = src; r.dst = dst;
    return r;
  endfunction

  // Reference model: one entry per unstalled issue cycle, derived from the step rules
  typedef struct {
    logic [25:0] instr;
    logic [7:0]  src, dst;
    int          addr;
  } beat_t;
  beat_t q[$];

  int          issues, cyc, steps, nwords;
  logic [25:0] w;
  beat_t       b;

  initial begin
    for (int i = 0; i < 8192; i++) imem[i] = '0;
    imem[0] = mkw(0, 10, 200, 3);
    imem[1] = mkw(1, 30, 40, 0);
    imem[2] = mkw(2, 50, 60, 5);
    imem[3] = mkw(0, 254, 255, 4);
    imem[4] = mkw(0, 100, 120, 5);
    imem[5] = mkw(0, 70, 80, 5);
    for (int i = 0; i < 4; i++) imem4[i] = mkw(2, 16 * i + 1, 16 * i + 2, 9);
    reset = 1'b1; start = 1'b0; hold = 1'b0;
    reset4 = 1'b1; start4 = 1'b0; hold4 = 1'b0;

    // Reset, idle, main issue sequence, wrap, hold, mid-instruction reset
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(v(0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 1, 10, 200));
    tbl.push_back(v(0, 1, 0, 0, 1, 11, 201));
    tbl.push_back(v(0, 1, 0, 0, 1, 12, 202));
    tbl.push_back(v(0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 1, 1, 30, 40));
    tbl.push_back(v(0, 1, 0, 2, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 2, 1, 50, 60));
    tbl.push_back(v(0, 1, 0, 3, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 3, 1, 254, 255));
    tbl.push_back(v(0, 1, 0, 3, 1, 255, 0));
    tbl.push_back(v(0, 1, 0, 3, 1, 0, 1));
    tbl.push_back(v(0, 1, 0, 3, 1, 1, 2));
    tbl.push_back(v(0, 1, 0, 4, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 4, 1, 100, 120));
    tbl.push_back(v(0, 1, 0, 4, 1, 101, 121));
    for (int i = 0; i < 3; i++) tbl.push_back(v(0, 1, 1, 4, 1, 101, 121));
    tbl.push_back(v(0, 1, 0, 4, 1, 102, 122));
    tbl.push_back(v(0, 1, 0, 4, 1, 103, 123));
    tbl.push_back(v(0, 1, 0, 4, 1, 104, 124));
    tbl.push_back(v(0, 1, 0, 5, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 5, 1, 70, 80));
    tbl.push_back(v(0, 1, 0, 5, 1, 71, 81));
    tbl.push_back(v(0, 1, 0, 5, 1, 72, 82));
    tbl.push_back(v(1, 1, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0));
    // start dropped mid-instruction: completes, idles at next pc, resumes there
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 1, 10, 200));
    tbl.push_back(v(0, 0, 0, 0, 1, 11, 201));
    tbl.push_back(v(0, 0, 0, 0, 1, 12, 202));
    tbl.push_back(v(0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 1, 1, 30, 40));
    tbl.push_back(v(0, 0, 0, 2, 0, 0, 0));

    @(negedge clock);
    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst; start = tbl[i].st; hold = tbl[i].hd;
      @(negedge clock);
      check($sformatf("row%0d addr", i),  64'(imem_addr),        64'(tbl[i].addr));
      check($sformatf("row%0d valid", i), 64'(instr_valid),      64'(tbl[i].val));
      check($sformatf("row%0d src", i),   64'(next_source),      64'(tbl[i].src));
      check($sformatf("row%0d dst", i),   64'(next_destination), 64'(tbl[i].dst));
      check($sformatf("row%0d done", i),  64'(done),             64'(0));
      if (tbl[i].rst) check($sformatf("row%0d instr", i), 64'(instruction), 64'(0));
    end

    // Four-word memory: four single-step issues, then DONE that start cannot leave
    reset4 = 1'b0; start4 = 1'b1;
    issues = 0;
    for (int c = 0; c < 40 && !done4; c++) begin
      @(negedge clock);
      if (instr_valid4) begin
        check($sformatf("d4 src%0d", issues), 64'(next_source4), 64'(16 * issues + 1));
        issues++;
      end
    end
    check("d4 issues", 64'(issues), 64'(4));
    check("d4 done", 64'(done4), 64'(1));
    check("d4 valid", 64'(instr_valid4), 64'(0));
    check("d4 instr", 64'(instruction4), 64'(imem4[3]));
    for (int c = 0; c < 6; c++) begin
      start4 = c[0];
      @(negedge clock);
      check($sformatf("d4 stay done%0d", c), 64'({done4, instr_valid4, imem_addr4}), 64'({1'b1, 1'b0, 2'd3}));
    end

    // Randomized stream against the beat-queue model
    nwords = 40;
    for (int i = 0; i < nwords; i++) begin
      w = 26'($urandom);
      imem[i] = w;
      steps = (w[25] == 1'b0 && w[5:0] != 6'd0) ? int'(w[5:0]) : 1;
      for (int k = 0; k < steps; k++) begin
        b.instr = w;
        b.src   = w[21:14] + 8'(k);
        b.dst   = w[13:6] + 8'(k);
        b.addr  = i;
        q.push_back(b);
      end
    end
    reset = 1'b1; start = 1'b0; hold = 1'b0;
    @(negedge clock);
    reset = 1'b0; start = 1'b1;
    cyc = 0;
    while (q.size() > 0 && cyc < 20000) begin
      @(negedge clock);
      cyc++;
      if (instr_valid) begin
        check("rnd instr", 64'(instruction),      64'(q[0].instr));
        check("rnd src",   64'(next_source),      64'(q[0].src));
        check("rnd dst",   64'(next_destination), 64'(q[0].dst));
        check("rnd addr",  64'(imem_addr),        64'(q[0].addr));
      end
      hold  = ($urandom_range(3) == 0);
      start = ($urandom_range(7) != 0);
      if (instr_valid && !hold) void'(q.pop_front());
    end
    check("rnd drained", 64'(q.size()), 64'(0));
    check("rnd done", 64'(done), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/transfer_sequencer.md
Name: transfer_sequencer

Overview:
- Instruction issue stage directly upstream of the processor and DMA blocks.
- Fetches 26-bit transfer instructions from instruction memory and holds each one on the shared instruction bus for as many cycles as its transfer count requires.
- Generates the per-cycle next_source / next_destination addresses that the processor and DMA consume.
- Replaces the ad-hoc instruction/offset logic currently carried in the system bench.

Parameters:
- IMEM_DEPTH, 8192, number of instruction memory words; the run ends after the last word.
- PC_W, 13, width of the instruction address (log2 IMEM_DEPTH).
- COUNT_W, 6, width of the transfer count field, instruction[5:0].

Ports:
- clock  in  1  single system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level run enable.
- hold  in  1  stall request (e.g. bus busy); freezes issue progress.
- imem_addr  out  PC_W  instruction memory address; equals the pc register.
- imem_data  in  26  instruction memory word; combinational read of imem_addr, valid the same cycle.
- instruction  out  26  currently issued instruction. Fields: [25:24] type, [23:22] sub, [21:14] src, [13:6] dest, [5:0] count.
- instr_valid  out  1  high while instruction is being issued.
- next_source  out  8  src + step, modulo 256.
- next_destination  out  8  dest + step, modulo 256.
- done  out  1  high once every instruction memory word has been issued.

Behaviour:
- Reset (wins over all other inputs, including mid-operation):
  - state=IDLE.
  - pc=0, step=0.
  - instruction=0, instr_valid=0, next_source=0, next_destination=0, done=0.
- Step total:
  - type 00 or 01 (block transfer): steps = count if count != 0, else 1.
  - type 10 or 11 (single transfer): steps = 1; count is ignored.
- FSM states: IDLE, FETCH, ISSUE, DONE.
- IDLE:
  - instr_valid=0.
  - start=1 -> FETCH; otherwise stay.
- FETCH (one cycle, instr_valid=0):
  - On the edge leaving FETCH: instruction <= imem_data, step <= 0, and go to ISSUE.
  - hold has no effect in this state.
- ISSUE:
  - instr_valid=1.
  - next_source = instruction[21:14] + step and next_destination = instruction[13:6] + step, each 8-bit with wrap 255 -> 0.
  - Both are combinational from registered step and instruction.
  - hold=1: step, pc and all outputs are frozen.
  - hold=0 and step < steps-1: step increments.
  - hold=0 and step == steps-1:
    - pc == IMEM_DEPTH-1 -> DONE.
    - else pc increments, then -> FETCH if start=1, or -> IDLE if start=0.
- Latency:
  - An instruction of N steps occupies N unstalled ISSUE cycles.
  - Exactly one FETCH bubble cycle (instr_valid=0) separates consecutive instructions.
  - The first instruction becomes valid 2 cycles after start rises in IDLE.
- start deasserted mid-instruction: the current instruction completes all its steps, then -> IDLE with pc retained; a later start resumes at pc.
- DONE:
  - done=1 and instr_valid=0.
  - instruction holds its last value.
  - Leave only by reset; start is ignored.
- pc never wraps.
- step is COUNT_W bits wide; the maximum is 63 steps (count=63).

Test Plan:
- Reset, then start=0 for 5 cycles -> all outputs 0; imem_addr=0; state stays IDLE.
- imem[0] = type 00, src 10, dest 200, count 3; start=1 ->
  - instr_valid high for 3 cycles.
  - next_source 10,11,12 and next_destination 200,201,202.
  - Then one bubble cycle; imem_addr=1.
- imem[1] = type 01 with count 0, imem[2] = type 10 with count 5 -> each issues exactly 1 cycle with next_source=src and next_destination=dest.
- imem[3] = type 00, src 254, dest 255, count 4 -> next_source 254,255,0,1 and next_destination 255,0,1,2.
- During the 2nd step of a count-5 instruction, hold=1 for 3 cycles -> outputs frozen for those cycles; the instruction completes after 5 unstalled cycles in total.
  - Repeat, but assert reset at step 2 -> all outputs 0 and IDLE on the next edge.
- Set IMEM_DEPTH=4 with all words single-step; start=1 -> 4 issues, then done=1 with instr_valid=0.
  - Toggling start has no effect afterwards.
  - Separately, drop start during an instruction -> it completes, then IDLE; restart resumes at the next pc.
